// File: rtl/frame_diff_pkg.sv
// Shared types and defaults for the frame-difference sequencer and its subtractor.
package frame_diff_pkg;

    localparam int FD_DATA_W       = 8;
    localparam int FD_ADDR_W       = 12;
    localparam int FD_FRAME_PIXELS = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SUB,
        S_CAPT,
        S_OUT,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/frame_diff_sequencer_sub.sv
// Absolute-difference subtractor: ready is taken while idle, operands one cycle later,
// and the result is presented for exactly one cycle after that (0 otherwise).
module frame_diff_sequencer_sub #(
    parameter int DATA_INPUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready_i,
    input  logic [DATA_INPUT-1:0] new_pixel_i,
    input  logic [DATA_INPUT-1:0] old_pixel_i,
    output logic [DATA_INPUT-1:0] frame_difference_o
);

    logic                  busy_q;
    logic [DATA_INPUT-1:0] diff_q;
    logic [DATA_INPUT-1:0] abs_diff;

    always_comb begin
        abs_diff = (new_pixel_i >= old_pixel_i) ? (new_pixel_i - old_pixel_i)
                                                : (old_pixel_i - new_pixel_i);
    end

    // busy_q marks the operand-sampling cycle; ready is ignored while it is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            diff_q <= '0;
        end else begin
            busy_q <= !busy_q && ready_i;
            diff_q <= busy_q ? abs_diff : '0;
        end
    end

    assign frame_difference_o = diff_q;

endmodule

// File: rtl/frame_diff_sequencer.sv
// Per-frame controller: reads both frame buffers pixel by pixel, streams |new-old|
// on a valid/ready port and counts pixels whose difference exceeds the threshold.
module frame_diff_sequencer
    import frame_diff_pkg::*;
#(
    parameter int DATA_W       = FD_DATA_W,
    parameter int ADDR_W       = FD_ADDR_W,
    parameter int FRAME_PIXELS = FD_FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] threshold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] new_rd_data,
    input  logic [DATA_W-1:0] old_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   motion_count,
    output seq_state_t        state_dbg
);

    // Output stream: a sample transfers on any cycle where out_valid and out_ready are
    // both high at the clock edge; out_valid, out_data and out_addr stay stable until then.

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] threshold_q;
    logic [ADDR_W-1:0] pix_cnt_q;
    logic [ADDR_W:0]   acc_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [ADDR_W:0]   motion_count_q;
    logic              sub_ready;
    logic [DATA_W-1:0] frame_difference;
    logic              over_thr;

    frame_diff_sequencer_sub #(
        .DATA_INPUT (DATA_W)
    ) u_sub (
        .clk                (clk),
        .reset              (reset),
        .ready_i            (sub_ready),
        .new_pixel_i        (new_rd_data),
        .old_pixel_i        (old_rd_data),
        .frame_difference_o (frame_difference)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  state_d = S_SUB;
            S_SUB:   state_d = S_CAPT;
            S_CAPT:  state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = (pix_cnt_q == LAST_PIX) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort overrides every transition, including a simultaneous start in S_IDLE
        if (abort) state_d = S_IDLE;
    end

    always_comb begin
        rd_en     = (state_q == S_READ);
        rd_addr   = rd_en ? pix_cnt_q : '0;
        sub_ready = rd_en && !abort;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
    end

    assign over_thr = (frame_difference > threshold_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            threshold_q    <= '0;
            pix_cnt_q      <= '0;
            acc_q          <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_addr_q     <= '0;
            motion_count_q <= '0;
        end else if (abort) begin
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    threshold_q <= threshold;
                    pix_cnt_q   <= '0;
                    acc_q       <= '0;
                end
                S_CAPT: begin
                    out_data_q  <= frame_difference;
                    out_addr_q  <= pix_cnt_q;
                    out_valid_q <= 1'b1;
                    acc_q       <= acc_q + {{ADDR_W{1'b0}}, over_thr};
                end
                S_OUT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    if (pix_cnt_q != LAST_PIX) pix_cnt_q <= pix_cnt_q + 1'b1;
                end
                S_DONE: motion_count_q <= acc_q;
                default: ;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_addr     = out_addr_q;
    assign motion_count = motion_count_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_frame_diff_sequencer.sv
// Directed bench for frame_diff_sequencer with a 4-pixel frame and a sync-read RAM model.
module tb_frame_diff_sequencer;
  import frame_diff_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 12;
  localparam int NPIX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] threshold = '0;
  logic [DW-1:0] new_rd_data = '0;
  logic [DW-1:0] old_rd_data = '0;
  logic          rd_en, out_valid, busy, done;
  logic [AW-1:0] rd_addr, out_addr;
  logic [DW-1:0] out_data;
  logic [AW:0]   motion_count;
  seq_state_t    state_dbg;

  logic [DW-1:0]    new_mem [NPIX];
  logic [DW-1:0]    old_mem [NPIX];
  logic [DW+AW-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int rd_count = 0;
  int done_total = 0;

  frame_diff_sequencer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_PIXELS(NPIX)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .threshold(threshold),
    .rd_en(rd_en), .rd_addr(rd_addr), .new_rd_data(new_rd_data), .old_rd_data(old_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done), .motion_count(motion_count), .state_dbg(state_dbg)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      new_rd_data <= new_mem[rd_addr[1:0]];
      old_rd_data <= old_mem[rd_addr[1:0]];
      rd_count    <= rd_count + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // checking helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [DW+AW-1:0] e;
    if (done) done_total++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("FAIL extra_out: observed addr %0d data %0d, expected no sample", out_addr, out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[DW+AW-1:AW]));
        check("out_addr", 32'(out_addr), 32'(e[AW-1:0]));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] a);
    exp_q.push_back({d, a});
  endtask

  task automatic load(input logic [DW-1:0] n0, n1, n2, n3, o0, o1, o2, o3);
    new_mem[0] = n0; new_mem[1] = n1; new_mem[2] = n2; new_mem[3] = n3;
    old_mem[0] = o0; old_mem[1] = o1; old_mem[2] = o2; old_mem[3] = o3;
  endtask

  // driver: one frame; threshold input is scrambled after start to prove it was latched
  task automatic run_frame(input logic [DW-1:0] thr, input int stall_pix, input int stall_len,
                           input logic [DW-1:0] stall_data, input int mid_start_c,
                           input int exp_done_c, input int exp_count);
    int c, done_c, d0, r0, stalls;
    d0 = done_total;
    r0 = rd_count;
    stalls = stall_len;
    done_c = -1;
    out_ready = 1'b1;
    threshold = thr;
    start = 1'b1;
    step();
    start = 1'b0;
    threshold = '0;
    c = 1;
    while (done_c < 0 && c < 200) begin
      start = (c == mid_start_c);
      if (out_valid && out_addr == AW'(stall_pix) && stalls > 0) begin
        out_ready = 1'b0;
        stalls--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid && !out_ready) begin
        check("held_data", 32'(out_data), 32'(stall_data));
        check("held_addr", 32'(out_addr), 32'(stall_pix));
      end
      sample();
      if (done) done_c = c;
      @(posedge clk);
      #1;
      c++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("done_cycle", 32'(done_c), 32'(exp_done_c));
    check("motion_count", 32'(motion_count), 32'(exp_count));
    check("busy_after", 32'(busy), 32'd0);
    check("rd_count", 32'(rd_count - r0), 32'(NPIX));
    repeat (3) step();
    check("done_pulses", 32'(done_total - d0), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_t1();
    push(8'd7, 12'd0); push(8'd4, 12'd1); push(8'd100, 12'd2); push(8'd0, 12'd3);
  endtask

  task automatic push_t5();
    push(8'd255, 12'd0); push(8'd0, 12'd1); push(8'd5, 12'd2); push(8'd6, 12'd3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_motion_count"}, 32'(motion_count), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  // directed sequence
  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic frame, threshold 4 -> 7 and 100 exceed it
    load(8'd10, 8'd5, 8'd200, 8'd0, 8'd3, 8'd9, 8'd100, 8'd0);
    push_t1();
    run_frame(8'd4, -1, 0, 8'd0, 0, 17, 2);

    // 2: back-pressure on pixel 1 for 3 cycles
    push_t1();
    run_frame(8'd4, 1, 3, 8'd4, 0, 20, 2);

    // 3: abort in S_SUB of pixel 2, then restart the very next cycle
    push(8'd7, 12'd0); push(8'd4, 12'd1);
    out_ready = 1'b1;
    threshold = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("pre_abort_state", 32'(state_dbg), 32'(S_SUB));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_state", 32'(state_dbg), 32'(S_IDLE));
    check("abort_motion_count", 32'(motion_count), 32'd2);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    load(8'd255, 8'd255, 8'd50, 8'd9, 8'd0, 8'd255, 8'd45, 8'd3);
    push_t5();
    run_frame(8'd254, -1, 0, 8'd0, 0, 17, 1);

    // 4: start pulsed mid-frame is ignored
    load(8'd10, 8'd5, 8'd200, 8'd0, 8'd3, 8'd9, 8'd100, 8'd0);
    push_t1();
    run_frame(8'd4, -1, 0, 8'd0, 6, 17, 2);

    // 5: diff equal to threshold is not counted (255 and 6 exceed 5, 5 does not)
    load(8'd255, 8'd255, 8'd50, 8'd9, 8'd0, 8'd255, 8'd45, 8'd3);
    push_t5();
    run_frame(8'd5, -1, 0, 8'd0, 0, 17, 2);

    // 6: asynchronous reset while holding pixel 0 in S_OUT
    load(8'd10, 8'd5, 8'd200, 8'd0, 8'd3, 8'd9, 8'd100, 8'd0);
    out_ready = 1'b0;
    threshold = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("pre_reset_state", 32'(state_dbg), 32'(S_OUT));
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_t1();
    run_frame(8'd4, -1, 0, 8'd0, 0, 17, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
